// File: rtl/quad_reg_pkg.sv
// Shared types and helpers for the quad register unloader.
package quad_reg_pkg;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  // Serial line level while no word is being unloaded (bank set state).
  localparam logic SO_IDLE_LVL = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/quad_reg_shifter.sv
// Loadable shift register with head-bit select; vacated positions fill with the idle level.
module quad_reg_shifter
  import quad_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             head
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      if (LSB_FIRST != 0) sr_d = {SO_IDLE_LVL, sr_q[WIDTH-1:1]};
      else                sr_d = {sr_q[WIDTH-2:0], SO_IDLE_LVL};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '1;
    else     sr_q <= sr_d;
  end

  assign head = (LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/quad_reg_unloader.sv
// Parallel-to-serial unloader with valid/ready on both sides.
// Define QUAD_REG_UNLOADER_PARITY_EN to append an even-parity beat after the data bits.
module quad_reg_unloader
  import quad_reg_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             CP,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SO,
  output logic             SO_VALID,
  input  logic             SO_READY,
  output logic             BUSY,
  output logic             DONE
);

`ifdef QUAD_REG_UNLOADER_PARITY_EN
  localparam int unsigned BEATS = WIDTH + 1;
`else
  localparam int unsigned BEATS = WIDTH;
`endif
  localparam int unsigned CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             sh_load, sh_shift, sh_head;
  logic [BEATS-1:0] sh_din;

`ifdef QUAD_REG_UNLOADER_PARITY_EN
  // Parity sits at the tail end so it leaves after the last data bit.
  logic par;
  assign par    = ^D;
  assign sh_din = (LSB_FIRST != 0) ? {par, D} : {D, par};
`else
  assign sh_din = D;
`endif

  quad_reg_shifter #(
    .WIDTH    (BEATS),
    .LSB_FIRST(LSB_FIRST)
  ) u_shifter (
    .clk  (CP),
    .rst  (RST),
    .load (sh_load),
    .shift(sh_shift),
    .din  (sh_din),
    .head (sh_head)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    LOAD_READY = 1'b0;
    SO_VALID   = 1'b0;
    BUSY       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        LOAD_READY = 1'b1;
        if (LOAD_VALID) begin
          sh_load = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        SO_VALID = 1'b1;
        BUSY     = 1'b1;
        if (SO_READY) begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign SO   = (state_q == ST_SHIFT) ? sh_head : SO_IDLE_LVL;
  assign DONE = done_q;

endmodule
